// File: rtl/ramseq_pkg.sv
// rtl/ramseq_pkg.sv - op and state encodings shared by the ramseq sequencer
package ramseq_pkg;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_DUMP = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DUMP = 2'd2
    } state_t;

endpackage

// File: rtl/ramasync.sv
// rtl/ramasync.sv - single-port RAM, synchronous write, combinational read
// Ports: clk; we/addr/din write port (written on rising edge when we);
//        dout = contents at addr, combinational.
module ramasync #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/ramseq.sv
// rtl/ramseq.sv - command sequencer that fills or dumps runs of an async-read RAM
// Ports: clk, nreset (async, active low);
//        cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_len/cmd_data  command in (len = words - 1);
//        rd_valid/rd_ready/rd_data/rd_last                     DUMP stream out;
//        busy                                                  not idle;
//        mem_we/mem_addr/mem_din/mem_dout                      RAM port.
module ramseq
    import ramseq_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] ptr;
    logic [AW-1:0] cnt;
    logic [DW-1:0] data;
    logic          remaining;   // DUMP words still to be read from the RAM
    logic          accept;
    logic          load;
    logic          last_hs;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mem_we    = (state == FILL);   // from state only, never from cmd_*/rd_ready
    assign mem_addr  = ptr;
    assign mem_din   = data;

    assign accept  = cmd_ready && cmd_valid;
    // Refill the output register when it is empty or being drained this edge.
    assign load    = (state == DUMP) && remaining && (!rd_valid || rd_ready);
    assign last_hs = (state == DUMP) && rd_valid && rd_ready && rd_last;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = (cmd_op == OP_DUMP) ? DUMP : FILL;
                end
            end
            FILL: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end
            end
            DUMP: begin
                if (last_hs) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr       <= '0;
            cnt       <= '0;
            data      <= '0;
            remaining <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else if (accept) begin
            ptr       <= cmd_addr;
            cnt       <= cmd_len;
            data      <= cmd_data;
            remaining <= (cmd_op == OP_DUMP);
        end else if (state == FILL) begin
            ptr <= ptr + AW'(1);
            cnt <= cnt - AW'(1);
        end else if (state == DUMP) begin
            if (load) begin
                rd_data  <= mem_dout;
                rd_valid <= 1'b1;
                rd_last  <= (cnt == '0);
                ptr      <= ptr + AW'(1);
                if (cnt == '0) begin
                    remaining <= 1'b0;
                end else begin
                    cnt <= cnt - AW'(1);
                end
            end else if (rd_valid && rd_ready) begin
                // Only the final beat drains without a reload, so this is also the exit.
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ramseq.md
# ramseq

Command-driven sequencer that owns the port of a single-port, asynchronous-read RAM (a ramasync instance) and moves data between the RAM and a streaming interface. It accepts one command at a time: FILL writes a constant to a run of consecutive addresses, and DUMP reads a run of addresses out on a valid/ready stream with backpressure. It sits between the benchmark's control/test logic and the memory macro, producing the RAM's we/addr/din and consuming its combinational dout.

## Interface
- DW, 16, data width; must match the attached RAM.
- AW, 8, address width; must match the attached RAM.
- clk  in  1  clock, rising-edge.
- nreset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  1  0 = FILL, 1 = DUMP.
- cmd_addr  in  AW  start address.
- cmd_len  in  AW  word count minus one (1 to 2^AW words).
- cmd_data  in  DW  FILL value; ignored for DUMP.
- rd_valid  out  1  DUMP beat valid.
- rd_ready  in  1  downstream accepts the beat.
- rd_data  out  DW  DUMP word, registered.
- rd_last  out  1  marks the final beat of a DUMP.
- busy  out  1  state != IDLE.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_din  out  DW  RAM write data.
- mem_dout  in  DW  RAM read data, combinational from mem_addr.

## Operation
- States are IDLE, FILL and DUMP. Registers: ptr (AW), cnt (AW), data (DW), rd_data, rd_valid, rd_last.
- Acceptance in IDLE: ptr <= cmd_addr, cnt <= cmd_len, data <= cmd_data, then go to FILL or DUMP according to cmd_op.
- mem_addr = ptr and mem_din = data at all times. mem_we = (state == FILL); it is combinational from state.
- FILL: every cycle, the RAM writes data to ptr. ptr increments and cnt decrements. On the edge where cnt == 0, go to IDLE.
- DUMP load condition: remaining && (!rd_valid || rd_ready), where remaining is a flag meaning words are still unread.
  - On load: rd_data <= mem_dout, rd_valid <= 1, rd_last <= (cnt == 0), and ptr increments.
  - If cnt == 0 on that load, clear remaining; otherwise decrement cnt.
  - If rd_valid && rd_ready && !load, then rd_valid <= 0.
- DUMP exit: when rd_valid && rd_ready && rd_last, go to IDLE, and rd_valid and rd_last go to 0 on the same edge.
- mem_we stays 0 throughout DUMP.
- Address arithmetic is modulo 2^AW, so a run that crosses 2^AW-1 wraps to 0 without error.
- rd_data holds its value while rd_valid && !rd_ready; it is never altered under backpressure.
- Reset, asynchronous and also mid-operation: state=IDLE, ptr=0, cnt=0, data=0, rd_data=0, rd_valid=0, rd_last=0. This gives mem_we=0, mem_addr=0, mem_din=0, busy=0 and cmd_ready=1 (once out of reset). A partially completed FILL leaves its already-written words in the RAM.

## Timing
- Command accepted at edge E0.
- FILL of N words: writes occur in the cycles after E0 through E(N). busy is high from E0 to E(N). cmd_ready rises after E(N).
- DUMP: the first beat is valid after E1, read from cmd_addr. With rd_ready held high, beat i is valid after E(1+i), giving one word per cycle. The final handshake returns the state to IDLE on the same edge.
- rd_ready low stalls both ptr and cnt; no RAM word is skipped or read twice.
- cmd_valid is ignored while busy. Back-to-back commands have a minimum gap of one IDLE cycle.
- There is no combinational path from cmd_* or rd_ready to mem_we.

## Structure
- Package ramseq_pkg holds:
  - the op encodings OP_FILL = 1'b0 and OP_DUMP = 1'b1;
  - the state encoding IDLE = 2'd0, FILL = 2'd1, DUMP = 2'd2.
- The block is a single module with no sub-module. The FSM, counters and output register fit in about 150–250 lines.
- The testbench instantiates ramseq connected to a ramasync with matching DW and AW.

## Test plan
- Reset check: assert nreset low mid-FILL at a random cycle -> all outputs take their reset values immediately. After release, cmd_ready=1 and the words written before reset hold cmd_data.
- FILL then DUMP: FILL addr=0x10, len=3, data=0xA5A5, then DUMP addr=0x0F, len=5, with rd_ready=1.
  - Required beats: old[0x0F], A5A5, A5A5, A5A5, A5A5, old[0x14].
  - rd_last appears only on the 6th beat.
  - cmd_ready rises after the FILL's 4 write cycles.
- Wrap-around: FILL addr=0xFE, len=3, data=0x1234 -> addresses 0xFE, 0xFF, 0x00, 0x01 are written. DUMP of the same range returns four beats of 0x1234.
- Backpressure: DUMP len=7 over a ramp pattern with rd_ready toggling pseudo-randomly -> exactly 8 beats, in order, with no duplicates and rd_data stable while stalled.
- Full-range run: FILL len=0xFF, data=0x5555 -> 256 write cycles, mem_we never high outside FILL. A following DUMP len=0xFF returns 256 beats of 0x5555.
- Busy rejection: hold cmd_valid=1 with a different op during a DUMP -> it is not accepted until cmd_ready returns. That command then executes once.
